// File: rtl/fp16_pkg.sv
// FP16 field layout, special encodings and classification helpers shared by the neuron datapath.
// Pure definitions: no latency, no backpressure.
package fp16_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
    endfunction

endpackage

// File: rtl/float_adder.sv
// Combinational FP16 adder, round-to-nearest-even, subnormals kept, x + (-x) gives +0.
// Zero latency, no handshake: the result settles in the same cycle as the operands.
module float_adder
    import fp16_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);

    fp16_t       w_a, w_b, w_big, w_small;
    logic [4:0]  w_eb, w_es, w_diff;
    logic [13:0] w_mb, w_ms, w_ms_sh, w_ms_j, w_norm;
    logic [14:0] w_raw;
    logic [6:0]  w_exp, w_lz, w_shift;
    logic [11:0] w_mant;
    logic        w_sticky, w_eff_sub, w_rnd_up, w_sign;
    logic [15:0] w_res;

    always_comb begin
        w_a   = fp16_t'(i_a);
        w_b   = fp16_t'(i_b);
        if (i_a[14:0] >= i_b[14:0]) begin
            w_big   = w_a;
            w_small = w_b;
        end else begin
            w_big   = w_b;
            w_small = w_a;
        end

        // Mantissas carry three extra bits (guard, round, sticky) below the LSB.
        w_eb     = (w_big.exp == 5'd0)   ? 5'd1 : w_big.exp;
        w_es     = (w_small.exp == 5'd0) ? 5'd1 : w_small.exp;
        w_mb     = {(w_big.exp != 5'd0), w_big.frac, 3'b000};
        w_ms     = {(w_small.exp != 5'd0), w_small.frac, 3'b000};
        w_diff   = w_eb - w_es;
        w_ms_sh  = w_ms >> w_diff;
        w_sticky = |(w_ms & ~(14'h3FFF << w_diff));
        w_ms_j   = {w_ms_sh[13:1], w_ms_sh[0] | w_sticky};

        w_eff_sub = w_big.sign ^ w_small.sign;
        w_raw     = w_eff_sub ? ({1'b0, w_mb} - {1'b0, w_ms_j})
                              : ({1'b0, w_mb} + {1'b0, w_ms_j});
        w_exp     = {2'b00, w_eb};
        w_lz      = 7'd14;
        w_shift   = 7'd0;
        w_norm    = w_raw[13:0];

        if (w_raw[14]) begin
            w_norm = {w_raw[14:2], w_raw[1] | w_raw[0]};
            w_exp  = w_exp + 7'd1;
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (w_raw[i]) w_lz = 7'(13 - i);
            end
            // Normalisation never drops the exponent below 1; what remains is subnormal.
            w_shift = (w_lz > (w_exp - 7'd1)) ? (w_exp - 7'd1) : w_lz;
            w_norm  = w_raw[13:0] << w_shift;
            w_exp   = w_exp - w_shift;
        end

        w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mant   = {1'b0, w_norm[13:3]} + {11'd0, w_rnd_up};
        if (w_mant[11]) begin
            w_mant = w_mant >> 1;
            w_exp  = w_exp + 7'd1;
        end

        w_sign = (w_eff_sub && (w_mant == 12'd0)) ? 1'b0 : w_big.sign;
        if (w_exp >= 7'd31) begin
            w_res = w_sign ? FP16_NINF : FP16_PINF;
        end else begin
            w_res = {w_sign, (w_mant[10] ? w_exp[4:0] : 5'd0), w_mant[9:0]};
        end

        if (is_nan(i_a) || is_nan(i_b)) begin
            o_sum = FP16_QNAN;
        end else if (is_inf(i_a) && is_inf(i_b) && (w_a.sign != w_b.sign)) begin
            o_sum = FP16_QNAN;
        end else if (is_inf(i_a)) begin
            o_sum = i_a;
        end else if (is_inf(i_b)) begin
            o_sum = i_b;
        end else begin
            o_sum = w_res;
        end
    end

endmodule

// File: rtl/fp16_neuron_accumulator.sv
// Accumulates N_INPUTS FP16 products plus bias into one neuron output with sticky NaN/overflow and optional ReLU.
// Result appears the cycle after the last beat; input stalls (in_ready=0) while the result waits for out_ready.
module fp16_neuron_accumulator
    import fp16_pkg::*;
#(
    parameter int N_INPUTS = 16,
    parameter int CNT_W    = $clog2(N_INPUTS + 1),
    parameter bit RELU_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_nan,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_acc, r_out_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_nan, r_ovf, r_out_ovf, r_out_nan;

    logic             w_beat, w_first, w_last;
    logic             w_nan_nxt, w_ovf_nxt;
    logic [15:0]      w_op_a, w_sum, w_acc_nxt, w_result;

    assign in_ready  = (r_state == IDLE) || (r_state == ACCUM);
    assign out_valid = (r_state == OUTPUT);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_nan   = r_out_nan;

    assign w_beat  = in_valid & in_ready;
    assign w_first = (r_state == IDLE);
    assign w_last  = w_first ? (N_INPUTS == 1) : (r_cnt == CNT_W'(N_INPUTS - 1));
    assign w_op_a  = w_first ? bias : r_acc;

    float_adder u_float_adder (
        .i_a   (w_op_a),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    // Once saturated the accumulator stays at the signed infinity for the rest of the neuron.
    assign w_acc_nxt = (!w_first && r_ovf) ? r_acc : w_sum;
    assign w_ovf_nxt = (!w_first && r_ovf) | is_inf(w_sum);
    assign w_nan_nxt = (!w_first && r_nan) | is_nan(in_data) | (w_first && is_nan(bias));
    assign w_result  = w_nan_nxt                  ? FP16_QNAN :
                       (RELU_EN && w_acc_nxt[15]) ? FP16_ZERO : w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_beat) w_state_nxt = w_last ? OUTPUT : ACCUM;
            ACCUM:   if (w_beat && w_last) w_state_nxt = OUTPUT;
            OUTPUT:  if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= FP16_ZERO;
            r_cnt      <= '0;
            r_nan      <= 1'b0;
            r_ovf      <= 1'b0;
            r_out_data <= FP16_ZERO;
            r_out_ovf  <= 1'b0;
            r_out_nan  <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_first ? CNT_W'(1) : r_cnt + CNT_W'(1);
            r_nan <= w_nan_nxt;
            r_ovf <= w_ovf_nxt;
            if (w_last) begin
                r_out_data <= w_result;
                r_out_ovf  <= w_ovf_nxt;
                r_out_nan  <= w_nan_nxt;
            end
        end else if ((r_state == OUTPUT) && out_ready) begin
            r_acc <= FP16_ZERO;
            r_cnt <= '0;
            r_nan <= 1'b0;
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp16_neuron_accumulator.sv
// Directed bench: two 4-input neurons (ReLU on/off) share stimulus, plus a 1-input neuron.
// Expected results are queued as beats are driven and popped when the result handshake occurs.
module tb_fp16_neuron_accumulator;

    typedef struct packed {
        logic [15:0] relu;
        logic [15:0] raw;
        logic        ovf;
        logic        nan;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_nan, busy;
    logic [15:0] in_data, bias, out_data;
    logic        nr_in_ready, nr_out_valid, nr_out_ovf, nr_out_nan, nr_busy;
    logic [15:0] nr_out_data;
    logic        n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready, n1_out_ovf, n1_out_nan, n1_busy;
    logic [15:0] n1_in_data, n1_bias, n1_out_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp16_neuron_accumulator #(.N_INPUTS(4), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bias(bias), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_nan(out_nan), .busy(busy)
    );

    fp16_neuron_accumulator #(.N_INPUTS(4), .RELU_EN(1'b0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nr_in_ready), .in_data(in_data),
        .bias(bias), .out_valid(nr_out_valid), .out_ready(out_ready), .out_data(nr_out_data),
        .out_ovf(nr_out_ovf), .out_nan(nr_out_nan), .busy(nr_busy)
    );

    fp16_neuron_accumulator #(.N_INPUTS(1), .RELU_EN(1'b1)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(n1_in_valid), .in_ready(n1_in_ready), .in_data(n1_in_data),
        .bias(n1_bias), .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_data(n1_out_data),
        .out_ovf(n1_out_ovf), .out_nan(n1_out_nan), .busy(n1_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_rdy", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic neuron(input logic [15:0] b, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3, input int gap, input exp_t e);
        bias = b;
        sb.push_back(e);
        send(d0, gap);
        send(d1, gap);
        send(d2, gap);
        send(d3, gap);
    endtask

    task automatic drain(input int hold, input string tag);
        int   n = 0;
        exp_t e;
        e = '0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, 16'(out_valid), 16'd1);
        check({tag, "_sb"}, 16'(sb.size()), 16'd1);
        if (sb.size() > 0) e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_rdy"}, 16'(in_ready), 16'd0);
            check({tag, "_hold_vld"}, 16'(out_valid), 16'd1);
            check({tag, "_hold_dat"}, out_data, e.relu);
        end
        check({tag, "_dat"}, out_data, e.relu);
        check({tag, "_raw"}, nr_out_data, e.raw);
        check({tag, "_ovf"}, 16'(out_ovf), 16'(e.ovf));
        check({tag, "_nan"}, 16'(out_nan), 16'(e.nan));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, 16'(busy), 16'd0);
        check({tag, "_nr_idle"}, 16'(nr_busy), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b0;
        n1_in_valid = 1'b0; n1_in_data = '0; n1_bias = '0; n1_out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_ovf_nan", {14'd0, out_ovf, out_nan}, 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back, result the cycle after the fourth beat
        bias = 16'h3C00;
        sb.push_back('{relu: 16'h4500, raw: 16'h4500, ovf: 1'b0, nan: 1'b0});
        send(16'h3C00, 0);
        send(16'h3C00, 0);
        send(16'h3C00, 0);
        check("t1_early_vld", 16'(out_valid), 16'd0);
        send(16'h3C00, 0);
        check("t1_lat_vld", 16'(out_valid), 16'd1);
        check("t1_lat_rdy", 16'(in_ready), 16'd0);
        drain(0, "t1");

        // 2: negative sum, ReLU clamps only the ReLU-enabled instance
        neuron(16'hC400, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 0,
               '{relu: 16'h0000, raw: 16'hC000, ovf: 1'b0, nan: 1'b0});
        drain(0, "t2");

        // 3: gapped input, then five cycles of backpressure
        neuron(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 1,
               '{relu: 16'h4500, raw: 16'h4500, ovf: 1'b0, nan: 1'b0});
        drain(5, "t3");

        // 4: saturation to +inf
        neuron(16'h7BFF, 16'h7BFF, 16'h3C00, 16'h3C00, 16'h3C00, 0,
               '{relu: 16'h7C00, raw: 16'h7C00, ovf: 1'b1, nan: 1'b0});
        drain(0, "t4");

        // 5: NaN term, and the following neuron starts clean
        neuron(16'h0000, 16'h3C00, 16'h7E01, 16'h3C00, 16'h3C00, 0,
               '{relu: 16'h7E00, raw: 16'h7E00, ovf: 1'b0, nan: 1'b1});
        drain(0, "t5");
        neuron(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0,
               '{relu: 16'h4500, raw: 16'h4500, ovf: 1'b0, nan: 1'b0});
        drain(0, "t5_next");

        // 6: reset mid-neuron with a beat presented at the same time
        bias = 16'h3C00;
        send(16'h3C00, 0);
        send(16'h3C00, 0);
        check("t6_busy", 16'(busy), 16'd1);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        rst_n    = 1'b0;
        tick();
        check("t6_rst_busy", 16'(busy), 16'd0);
        check("t6_rst_vld", 16'(out_valid), 16'd0);
        check("t6_rst_dat", out_data, 16'h0000);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        neuron(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 0,
               '{relu: 16'h4500, raw: 16'h4500, ovf: 1'b0, nan: 1'b0});
        drain(0, "t6");

        // single-input neuron: bias folded with the only beat
        n1_bias     = 16'h4000;
        n1_in_data  = 16'h3C00;
        n1_in_valid = 1'b1;
        check("n1_rdy", 16'(n1_in_ready), 16'd1);
        tick();
        n1_in_valid = 1'b0;
        check("n1_vld", 16'(n1_out_valid), 16'd1);
        check("n1_dat", n1_out_data, 16'h4200);
        check("n1_flags", {14'd0, n1_out_ovf, n1_out_nan}, 16'd0);
        n1_out_ready = 1'b1;
        tick();
        n1_out_ready = 1'b0;
        check("n1_idle", 16'(n1_busy), 16'd0);

        check("sb_leftover", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
